// File: rtl/write_arb_pkg.sv
// Shared types and helpers for the round-robin write channel mux.
// State encoding is only used when WCRM_PACKET_LOCK_EN is defined.
package write_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } wr_state_e;

  // Port-index width, never less than one bit so a single-port build still has a port field.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/write_channel_rr_mux_arbiter.sv
// Round-robin arbiter: searches a doubled request vector above ptr, or
// grants only hold_idx while hold is asserted.
module rr_arbiter
  import write_arb_pkg::*;
#(
  parameter int N = 16,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             hold,
  input  logic [SEL_W-1:0] hold_idx,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_mask;
  logic           w_found;

  assign w_dbl = {req, req};

  // Window (ptr, ptr+N] over the doubled vector covers every port once, starting after ptr.
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < 2*N; j++) begin
      w_mask[j] = (j > int'(ptr)) && (j <= int'(ptr) + N);
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    if (hold) begin
      if (req[hold_idx]) begin
        grant[hold_idx] = 1'b1;
        grant_idx       = hold_idx;
      end
    end else begin
      for (int j = 0; j < 2*N; j++) begin
        if (!w_found && w_dbl[j] && w_mask[j]) begin
          w_found   = 1'b1;
          grant_idx = SEL_W'((j >= N) ? (j - N) : j);
        end
      end
      if (w_found) grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/write_channel_rr_mux.sv
// Round-robin write channel mux with a registered valid/ready output stage.
// Define WCRM_PACKET_LOCK_EN to hold the grant on one port until its last beat.
module write_channel_rr_mux
  import write_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 16,
  parameter int DATA_WIDTH = 64,
  localparam int SEL_W     = sel_width(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS-1:0]            in_last,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [SEL_W-1:0]                out_port,
  output logic                            out_last,
  output logic                            busy
);

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0]      r_out_port;
  logic                  r_out_last;
  logic [SEL_W-1:0]      r_rr_ptr;

  logic                  w_can_load;
  logic [NUM_PORTS-1:0]  w_grant;
  logic [SEL_W-1:0]      w_grant_idx;
  logic                  w_accept;
  logic                  w_hold;
  logic [SEL_W-1:0]      w_hold_idx;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;

`ifdef WCRM_PACKET_LOCK_EN
  wr_state_e        r_state;
  logic [SEL_W-1:0] r_lock_port;

  assign w_hold     = (r_state == ST_LOCK);
  assign w_hold_idx = r_lock_port;
  assign busy       = (r_state == ST_LOCK);
`else
  assign w_hold     = 1'b0;
  assign w_hold_idx = '0;
  assign busy       = 1'b0;
`endif

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .hold      (w_hold),
    .hold_idx  (w_hold_idx),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_can_load = !r_out_valid || out_ready;
  assign in_ready   = w_can_load ? w_grant : '0;
  assign w_accept   = |(in_valid & in_ready);
  assign w_sel_data = in_data[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_last = in_last[w_grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_port  <= '0;
      r_out_last  <= 1'b0;
      r_rr_ptr    <= SEL_W'(NUM_PORTS - 1);
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_port  <= w_grant_idx;
      r_out_last  <= w_sel_last;
      r_rr_ptr    <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef WCRM_PACKET_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lock_port <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_sel_last) begin
            r_state     <= ST_LOCK;
            r_lock_port <= w_grant_idx;
          end
        end
        ST_LOCK: begin
          if (w_sel_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_port  = r_out_port;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_write_channel_rr_mux.sv
// Directed bench for write_channel_rr_mux (16 ports x 64 bits); covers the
// packet-lock build when WCRM_PACKET_LOCK_EN is defined.
module tb_write_channel_rr_mux;

  localparam int NP = 16;
  localparam int DW = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_last;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [3:0]       out_port;
  logic             out_last;
  logic             busy;

  int checks = 0;
  int errors = 0;

  write_channel_rr_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int port, input int k);
    return 64'hA500_0000_0000_0000 | (64'(k) << 16) | 64'(port);
  endfunction

  task automatic set_data(input int k);
    for (int i = 0; i < NP; i++) in_data[i*DW +: DW] = pat(i, k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = '0; in_last = '1; out_ready = 1'b1; set_data(0);
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data got %0h want 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid c%0d got %0b want 0", c, out_valid); end
      checks++; if (in_ready !== '0) begin errors++; $display("FAIL idle_ready c%0d got %0h want 0", c, in_ready); end
      checks++; if (out_port !== 4'd0) begin errors++; $display("FAIL idle_port c%0d got %0d want 0", c, out_port); end
    end
  endtask

  task automatic test_two_ports();
    logic [3:0] exp_port [4];
    exp_port[0] = 4'd0; exp_port[1] = 4'd15; exp_port[2] = 4'd0; exp_port[3] = 4'd15;
    set_data(2); in_last = '1; out_ready = 1'b1;
    in_valid = 16'h8001;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL two_valid b%0d got %0b want 1", k, out_valid); end
      checks++; if (out_port !== exp_port[k]) begin errors++; $display("FAIL two_port b%0d got %0d want %0d", k, out_port, exp_port[k]); end
      checks++; if (out_data !== pat(int'(exp_port[k]), 2)) begin errors++; $display("FAIL two_data b%0d got %0h want %0h", k, out_data, pat(int'(exp_port[k]), 2)); end
    end
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_drain got %0b want 0", out_valid); end
    checks++; if (out_data !== pat(15, 2)) begin errors++; $display("FAIL two_keep got %0h want %0h", out_data, pat(15, 2)); end
  endtask

  task automatic test_all_ports();
    set_data(3); in_last = '1; out_ready = 1'b1;
    in_valid = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL all_valid b%0d got %0b want 1", k, out_valid); end
      checks++; if (out_port !== 4'(k % 16)) begin errors++; $display("FAIL all_port b%0d got %0d want %0d", k, out_port, k % 16); end
      checks++; if (out_data !== pat(k % 16, 3)) begin errors++; $display("FAIL all_data b%0d got %0h want %0h", k, out_data, pat(k % 16, 3)); end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_stall();
    set_data(4); in_last = '1; out_ready = 1'b1;
    in_valid = 16'h0004;
    tick();
    checks++; if (out_port !== 4'd2) begin errors++; $display("FAIL stall_load got %0d want 2", out_port); end
    out_ready = 1'b0; in_valid = 16'h0010; set_data(5);
    #1;
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL stall_ready0 got %0h want 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d got %0b want 1", c, out_valid); end
      checks++; if (out_port !== 4'd2) begin errors++; $display("FAIL stall_port c%0d got %0d want 2", c, out_port); end
      checks++; if (out_data !== pat(2, 4)) begin errors++; $display("FAIL stall_data c%0d got %0h want %0h", c, out_data, pat(2, 4)); end
      checks++; if (in_ready !== '0) begin errors++; $display("FAIL stall_ready c%0d got %0h want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 16'h0010) begin errors++; $display("FAIL release_ready got %0h want 0010", in_ready); end
    tick();
    checks++; if (out_port !== 4'd4) begin errors++; $display("FAIL release_port got %0d want 4", out_port); end
    checks++; if (out_data !== pat(4, 5)) begin errors++; $display("FAIL release_data got %0h want %0h", out_data, pat(4, 5)); end
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drain got %0b want 0", out_valid); end
  endtask

`ifdef WCRM_PACKET_LOCK_EN
  task automatic test_packet_lock();
    do_reset();
    set_data(6); out_ready = 1'b1;
    in_last = 16'hFFF7;
    in_valid = 16'h0028;
    for (int b = 0; b < 2; b++) begin
      tick();
      checks++; if (out_port !== 4'd3) begin errors++; $display("FAIL lock_port b%0d got %0d want 3", b, out_port); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy b%0d got %0b want 1", b, busy); end
    end
    in_valid = 16'h0020;
    #1;
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL lock_gap_ready got %0h want 0", in_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lock_gap_valid c%0d got %0b want 0", c, out_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_gap_busy c%0d got %0b want 1", c, busy); end
    end
    in_valid = 16'h0028;
    tick();
    checks++; if (out_port !== 4'd3) begin errors++; $display("FAIL lock_b3 got %0d want 3", out_port); end
    in_last = 16'hFFFF;
    tick();
    checks++; if (out_port !== 4'd3) begin errors++; $display("FAIL lock_b4 got %0d want 3", out_port); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL lock_b4_last got %0b want 1", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_release got %0b want 0", busy); end
    in_valid = 16'h0020;
    tick();
    checks++; if (out_port !== 4'd5) begin errors++; $display("FAIL lock_next got %0d want 5", out_port); end
    in_valid = '0;
    tick();
  endtask
`else
  task automatic test_no_lock();
    do_reset();
    set_data(6); out_ready = 1'b1;
    in_last = 16'hFFF7;
    in_valid = 16'h0028;
    tick();
    checks++; if (out_port !== 4'd3) begin errors++; $display("FAIL nolock_first got %0d want 3", out_port); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nolock_busy got %0b want 0", busy); end
    tick();
    checks++; if (out_port !== 4'd5) begin errors++; $display("FAIL nolock_rearb got %0d want 5", out_port); end
    in_valid = '0;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    set_data(7); out_ready = 1'b1;
    in_last = 16'hFFF7;
    in_valid = 16'h0008;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0b want 1", out_valid); end
`ifdef WCRM_PACKET_LOCK_EN
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got %0b want 1", busy); end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", busy); end
    in_last = '1;
    in_valid = 16'hFFFF;
    tick();
    checks++; if (out_port !== 4'd0) begin errors++; $display("FAIL mid_first got %0d want 0", out_port); end
    checks++; if (out_data !== pat(0, 7)) begin errors++; $display("FAIL mid_data got %0h want %0h", out_data, pat(0, 7)); end
    in_valid = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_two_ports();
    test_all_ports();
    test_stall();
`ifdef WCRM_PACKET_LOCK_EN
    test_packet_lock();
`else
    test_no_lock();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
